// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer_if
// Description : Instruction fetch bus shared by the fetch sequencer and its
//               environment. The ROM port, redirect/halt controls and the
//               consumer handshake are bundled here.
//               master = fetch sequencer side, slave = ROM/consumer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_sequencer_if;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic        halt_req;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        out_ready;
    logic        fault;
    logic [1:0]  state;

    modport master (
        output imem_addr,
        input  imem_instr,
        input  redirect_valid,
        input  redirect_target,
        input  halt_req,
        output out_valid,
        output out_instr,
        output out_pc,
        input  out_ready,
        output fault,
        output state
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        output redirect_valid,
        output redirect_target,
        output halt_req,
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output out_ready,
        input  fault,
        input  state
    );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Instruction fetch sequencer. Drives a combinational ROM from
//               the fetch PC and buffers {pc, instr} pairs in a 2-entry FIFO
//               toward the consumer. Supports redirect (flush + reload),
//               halt, and an optional terminal fault state.
//               Optional feature macro: FETCH_BOUNDS_CHECK_EN enables
//               alignment / memory-bounds checking of each fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int          MEM_SIZE = 1024,
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  wire logic clk,
    input  wire logic reset,
    fetch_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t      r_state;
    logic [63:0] r_fpc;
    logic [63:0] r_pc    [2];
    logic [31:0] r_instr [2];
    logic        r_wptr;
    logic        r_rptr;
    logic [1:0]  r_count;

    logic        w_push;
    logic        w_pop;
    logic        w_flush;
    logic        w_fault_hit;
    logic        w_space;
    logic        w_bad;
    logic [63:0] w_target;

`ifdef FETCH_BOUNDS_CHECK_EN
    logic        r_fault;

    // A fetch is illegal if misaligned or if any byte lies past the ROM end.
    assign w_bad    = (r_fpc[1:0] != 2'b00) ||
                      (({1'b0, r_fpc} + 65'd3) >= 65'(MEM_SIZE));
    assign w_target = bus.redirect_target;
    assign bus.fault = r_fault;
`else
    logic        w_unused_cfg;

    // Without checking, redirect targets are forced word-aligned instead.
    assign w_bad        = 1'b0;
    assign w_target     = {bus.redirect_target[63:2], 2'b00};
    assign bus.fault    = 1'b0;
    assign w_unused_cfg = (MEM_SIZE > 4) ^ bus.redirect_target[1] ^ bus.redirect_target[0];
`endif

    assign bus.imem_addr = r_fpc;
    assign bus.out_valid = (r_count != 2'd0);
    assign bus.out_pc    = r_pc[r_rptr];
    assign bus.out_instr = r_instr[r_rptr];
    assign bus.state     = r_state;

    // A full FIFO can still accept when its head leaves on the same edge.
    assign w_space = (r_count != 2'd2) || (bus.out_valid && bus.out_ready);

    // Per-edge decisions: redirect wins over everything, halt blocks fetch.
    always_comb begin
        w_flush     = 1'b0;
        w_push      = 1'b0;
        w_fault_hit = 1'b0;
        w_pop       = bus.out_valid && bus.out_ready;
        case (r_state)
            ST_RUN: begin
                if (bus.redirect_valid) begin
                    w_flush = 1'b1;
                end else if (!bus.halt_req && w_space) begin
                    if (w_bad) begin
                        w_fault_hit = 1'b1;
                    end else begin
                        w_push = 1'b1;
                    end
                end
            end
            ST_HALT: begin
                if (bus.redirect_valid) begin
                    w_flush = 1'b1;
                end
            end
            default: begin
            end
        endcase
        if (w_flush) begin
            w_pop = 1'b0;
        end
    end

    // FSM, fetch PC and FIFO storage, all updated together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
            r_fpc   <= RESET_PC;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_pc[i]    <= 64'd0;
                r_instr[i] <= 32'd0;
            end
`ifdef FETCH_BOUNDS_CHECK_EN
            r_fault <= 1'b0;
`endif
        end else begin
            if (w_flush) begin
                r_count <= 2'd0;
                r_wptr  <= 1'b0;
                r_rptr  <= 1'b0;
                r_fpc   <= w_target;
            end else begin
                if (w_push) begin
                    r_pc[r_wptr]    <= r_fpc;
                    r_instr[r_wptr] <= bus.imem_instr;
                    r_wptr          <= ~r_wptr;
                    r_fpc           <= r_fpc + 64'd4;
                end
                if (w_pop) begin
                    r_rptr <= ~r_rptr;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 2'd1;
                    2'b01:   r_count <= r_count - 2'd1;
                    default: r_count <= r_count;
                endcase
            end

            case (r_state)
                ST_RUN: begin
                    if (bus.halt_req) begin
                        r_state <= ST_HALT;
                    end else if (w_fault_hit) begin
                        r_state <= ST_FAULT;
                    end
                end
                ST_HALT: begin
                    if (bus.redirect_valid) begin
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_FAULT;
            endcase

`ifdef FETCH_BOUNDS_CHECK_EN
            if (w_fault_hit) begin
                r_fault <= 1'b1;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 1024, instruction memory size in bytes (power of two, >4).
REQ-002 SHALL have parameter RESET_PC, default 0, byte address of the first fetch after reset.
REQ-003 SHALL have clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have imem_addr  output  64  byte address driven to the combinational instruction ROM.
REQ-006 SHALL have imem_instr  input  32  ROM read data for imem_addr, valid in the same cycle.
REQ-007 SHALL have redirect_valid  input  1  branch/jump redirect request, single-cycle pulse.
REQ-008 SHALL have redirect_target  input  64  new fetch byte address, sampled when redirect_valid=1.
REQ-009 SHALL have halt_req  input  1  stop fetching after the current cycle.
REQ-010 SHALL have out_valid  output  1  buffer head holds a valid instruction.
REQ-011 SHALL have out_instr  output  32  instruction at buffer head.
REQ-012 SHALL have out_pc  output  64  byte address of out_instr.
REQ-013 SHALL have out_ready  input  1  consumer accepts head when out_valid=1.
REQ-014 SHALL have fault  output  1  sticky fetch-fault flag.
REQ-015 SHALL have state  output  2  current FSM state (RUN=0, HALT=1, FAULT=2).

Function
REQ-016 SHALL hold fetch PC register fpc and drive imem_addr=fpc continuously.
REQ-017 SHALL contain a 2-entry FIFO of {pc, instr}; head drives out_pc/out_instr; out_valid=(count!=0).
REQ-018 Dequeue SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-019 In RUN with no redirect, enqueue {fpc, imem_instr} and set fpc<=fpc+4 when count<2, or count==2 with dequeue in the same edge.
REQ-020 Simultaneous enqueue and dequeue SHALL leave count unchanged; FIFO pointers wrap modulo 2.
REQ-021 A redirect SHALL take priority over enqueue and dequeue: flush FIFO (count<=0), fpc<=redirect_target, no enqueue that edge.
REQ-022 Redirect latency: redirect sampled at edge N; target instruction enqueued at edge N+1; out_valid=1 after edge N+1.
REQ-023 fpc arithmetic SHALL be 64-bit unsigned, wrapping modulo 2^64.
REQ-024 RUN -> HALT when halt_req=1 (no enqueue that edge); HALT performs no enqueue, FIFO continues to drain.
REQ-025 HALT -> RUN only on redirect (flush and load fpc as REQ-021); halt_req is ignored while in HALT.
REQ-026 Redirect and halt_req on the same edge in RUN: redirect applied, state goes to HALT.
REQ-027 FAULT SHALL be terminal until reset; in FAULT, no enqueue, redirect ignored, FIFO still drains.

Reset
REQ-028 While reset=0: fpc=RESET_PC, state=RUN, count=0, pointers=0, out_valid=0, out_instr=0, out_pc=0, fault=0; effective immediately, independent of clk.
REQ-029 First enqueue SHALL occur on the first rising edge with reset=1; assertion mid-operation discards FIFO contents and pending redirects.

Configuration
REQ-030 Macro FETCH_BOUNDS_CHECK_EN SHALL select fetch bounds checking.
REQ-031 Defined: an enqueue attempt with fpc[1:0]!=0 or fpc+3>=MEM_SIZE SHALL not enqueue, SHALL enter FAULT, and fault<=1 on that edge.
REQ-032 Not defined: no check; fault tied 0; FAULT unreachable; redirect_target[1:0] forced to 0 when loaded into fpc.

Verification
REQ-033 Reset release, out_ready=1, ROM word k = k -> out_pc 0,4,8,... one per cycle; out_valid=1 after first edge.
REQ-034 out_ready=0 for 5 cycles -> count saturates at 2, fpc=8, heads pc 0 then 4 retained; resume yields 0,4,8 with no gaps or duplicates.
REQ-035 Redirect to 0x40 while FIFO full -> next valid out_pc=0x40, one bubble cycle, no stale pc 0x8.
REQ-036 halt_req at pc 0x10 -> FIFO drains, out_valid=0, state=1; redirect to 0x0 -> state=0, out_pc=0x0 next.
REQ-037 With FETCH_BOUNDS_CHECK_EN, MEM_SIZE=1024, redirect to 0x3FC -> 0x3FC delivered, then fault=1, state=2; redirect to 0x3FE -> fault on first fetch; without macro 0x3FE loads fpc=0x3FC.
REQ-038 reset pulsed low mid-stream, asynchronously between edges -> outputs zero immediately, restart at RESET_PC.
